// File: rtl/anti_theft_controller_if.sv
// Switch inputs, 1 Hz / 2 Hz enables and status outputs of the anti-theft FSM.
// Optional ANTI_THEFT_FUEL_PUMP_EN adds the fuel-pump interlock signals.
interface anti_theft_controller_if;
  logic       one_hz_enable;
  logic       two_hz_enable;
  logic       ignition;
  logic       driver_door;
  logic       passenger_door;
  logic       reprogram;
  logic       enable_siren;
  logic       status_led;
  logic [2:0] state_code;
  logic [3:0] timer_value;
`ifdef ANTI_THEFT_FUEL_PUMP_EN
  logic       hidden_switch;
  logic       brake;
  logic       fuel_pump_power;

  modport master (
    output one_hz_enable, two_hz_enable, ignition, driver_door, passenger_door,
           reprogram, hidden_switch, brake,
    input  enable_siren, status_led, state_code, timer_value, fuel_pump_power
  );
  modport slave (
    input  one_hz_enable, two_hz_enable, ignition, driver_door, passenger_door,
           reprogram, hidden_switch, brake,
    output enable_siren, status_led, state_code, timer_value, fuel_pump_power
  );
`else
  modport master (
    output one_hz_enable, two_hz_enable, ignition, driver_door, passenger_door,
           reprogram,
    input  enable_siren, status_led, state_code, timer_value
  );
  modport slave (
    input  one_hz_enable, two_hz_enable, ignition, driver_door, passenger_door,
           reprogram,
    output enable_siren, status_led, state_code, timer_value
  );
`endif
endinterface

// File: rtl/anti_theft_controller.sv
// Anti-theft sequencing FSM: arming, entry-delay and alarm countdowns on the 1 Hz enable.
// Define ANTI_THEFT_FUEL_PUMP_EN to add the hidden-switch fuel-pump interlock.
module anti_theft_controller #(
  parameter logic [3:0] T_ARM       = 4'd6,
  parameter logic [3:0] T_DRIVER    = 4'd8,
  parameter logic [3:0] T_PASSENGER = 4'd15,
  parameter logic [3:0] T_ALARM     = 4'd10
) (
  input logic                     clock,
  input logic                     reset,
  anti_theft_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    ARMED      = 3'd0,
    TRIGGERED  = 3'd1,
    ALARM      = 3'd2,
    DISARMED   = 3'd3,
    WAIT_OPEN  = 3'd4,
    WAIT_CLOSE = 3'd5,
    ARM_DELAY  = 3'd6,
    ILLEGAL    = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic       led_q, led_d;
  logic [3:0] timer_dec;
  logic       expire;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ARMED;
      timer_q <= 4'd0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      led_q   <= led_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = 4'd0;
    led_d     = 1'b0;
    expire    = bus.one_hz_enable && (timer_q == 4'd1);
    timer_dec = (bus.one_hz_enable && timer_q != 4'd0) ? timer_q - 4'd1 : timer_q;

    if (bus.reprogram) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED: begin
          if (bus.ignition) state_d = DISARMED;
          else if (bus.driver_door) begin
            state_d = TRIGGERED;
            timer_d = T_DRIVER;
          end else if (bus.passenger_door) begin
            state_d = TRIGGERED;
            timer_d = T_PASSENGER;
          end
        end
        TRIGGERED: begin
          if (bus.ignition) state_d = DISARMED;
          else if (expire) begin
            state_d = ALARM;
            timer_d = T_ALARM;
          end else timer_d = timer_dec;
        end
        ALARM: begin
          // an open door keeps the siren going for a full T_ALARM after it closes
          if (bus.ignition) state_d = DISARMED;
          else if (bus.driver_door || bus.passenger_door) timer_d = T_ALARM;
          else if (expire) state_d = ARMED;
          else timer_d = timer_dec;
        end
        DISARMED: begin
          if (!bus.ignition) state_d = WAIT_OPEN;
        end
        WAIT_OPEN: begin
          if (bus.ignition) state_d = DISARMED;
          else if (bus.driver_door) state_d = WAIT_CLOSE;
        end
        WAIT_CLOSE: begin
          if (bus.ignition) state_d = DISARMED;
          else if (!bus.driver_door) begin
            state_d = ARM_DELAY;
            timer_d = T_ARM;
          end
        end
        ARM_DELAY: begin
          if (bus.ignition) state_d = DISARMED;
          else if (bus.driver_door) state_d = WAIT_CLOSE;
          else if (expire) state_d = ARMED;
          else timer_d = timer_dec;
        end
        default: state_d = ARMED;
      endcase
    end

    // LED follows the next state so it changes on the same edge as the state
    case (state_d)
      ARMED:            led_d = (state_q != ARMED) ? 1'b0 : (led_q ^ bus.two_hz_enable);
      TRIGGERED, ALARM: led_d = 1'b1;
      default:          led_d = 1'b0;
    endcase
  end

  assign bus.enable_siren = (state_q == ALARM);
  assign bus.status_led   = led_q;
  assign bus.state_code   = state_q;
  assign bus.timer_value  = timer_q;

`ifdef ANTI_THEFT_FUEL_PUMP_EN
  logic fuel_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                                fuel_q <= 1'b0;
    else if (!bus.ignition || state_q == ALARM)               fuel_q <= 1'b0;
    else if (bus.ignition && bus.hidden_switch && bus.brake)  fuel_q <= 1'b1;
  end

  assign bus.fuel_pump_power = fuel_q;
`endif

endmodule
